byte_packer: RTL and testbench
==============================

BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 Parameter: NBYTES, default 4; bytes per output word, legal values 2..8.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_byte  input  8  byte from the serial source.
REQ-005 Port: in_valid  input  1  in_byte is valid this cycle.
REQ-006 Port: in_ready  output  1  block accepts in_byte this cycle.
REQ-007 Port: big_endian  input  1  1 = first byte lands in the MSB lane; 0 = first byte lands in the LSB lane.
REQ-008 Port: flush  input  1  emit the partially assembled word now.
REQ-009 Port: out_word  output  8*NBYTES  assembled word.
REQ-010 Port: out_nbytes  output  $clog2(NBYTES+1)  count of valid bytes in out_word.
REQ-011 Port: out_valid  output  1  out_word/out_nbytes valid.
REQ-012 Port: out_ready  input  1  downstream consumes out_word this cycle.

Function
REQ-013 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-014 The block SHALL hold an assembly register, a lane counter cnt (0..NBYTES-1) and a one-entry output register.
REQ-015 The block SHALL implement a two-state FSM: FILL (output register empty) and HOLD (output register occupied).
REQ-016 On each input transfer, byte k of the word (k = cnt) SHALL be written to lane NBYTES-1-k when the latched mode is big_endian=1, or to lane k when it is 0.
REQ-017 The endian mode SHALL be latched on the transfer with cnt==0 and SHALL remain fixed for the rest of that word.
REQ-018 When cnt==NBYTES-1 and an input transfer occurs, the full word SHALL move to the output register on the same edge, with out_nbytes=NBYTES; cnt SHALL return to 0 and the assembly register SHALL clear to 0.
REQ-019 in_ready SHALL be 0 only when cnt==NBYTES-1 && out_valid && !out_ready; it SHALL be 1 otherwise, so a simultaneous drain and completion sustains 1 byte/cycle.
REQ-020 On flush with cnt>0 and the output register free (FILL, or HOLD with out_ready=1), the partial word SHALL move to the output register with unused lanes zero and out_nbytes=cnt (plus 1 if an input transfer occurs in the same cycle); cnt SHALL return to 0.
REQ-021 A flush while the output register is blocked SHALL remain pending internally and SHALL take effect on the first cycle the register frees; in_ready SHALL be 0 while a flush is pending.
REQ-022 A flush with cnt==0 and no input transfer SHALL be ignored, and no zero-byte word SHALL ever be emitted.
REQ-023 A flush coinciding with completion of a full word SHALL produce only the full word, with no extra empty word.
REQ-024 FSM transitions: FILL->HOLD on a word move; HOLD->FILL on an output transfer without a simultaneous word move; HOLD->HOLD when both occur.
REQ-025 out_word and out_nbytes SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 Latency from the last input byte transfer to out_valid=1 SHALL be 1 cycle.

Reset
REQ-027 On reset=1 at a clock edge: FSM=FILL, cnt=0, assembly register=0, out_word=0, out_nbytes=0, out_valid=0, pending flush cleared, latched mode=1.
REQ-028 During reset, in_ready SHALL be 0.
REQ-029 A reset asserted mid-word or mid-hold SHALL discard all partial and held data, and the first word after reset SHALL start at cnt=0.

Structure
REQ-030 A shared package byte_packer_pkg SHALL hold the FSM state enum (FILL, HOLD) and the default NBYTES constant.
REQ-031 The one-entry output register with valid/ready SHALL be a sub-module named out_reg_slice; the lane steering and counter SHALL stay in byte_packer.

Verification
REQ-032 big_endian=1, bytes 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=1 -> out_word=0x11223344, out_nbytes=4, out_valid 1 cycle after 0x44.
REQ-033 big_endian=0, same bytes -> out_word=0x44332211; toggling big_endian after byte 0x11 has no effect on that word.
REQ-034 out_ready=0 with 8 bytes streamed -> first word held stable, in_ready=0 at 4th byte of second word; raise out_ready -> both words delivered in order, with no loss or duplication.
REQ-035 Bytes 0xAA,0xBB then flush (big_endian=1) -> out_word=0xAABB0000, out_nbytes=2; flush with cnt==0 produces no output.
REQ-036 Reset asserted after 3 bytes -> all outputs 0; the next 4 bytes 0x01..0x04 (big_endian=1) produce 0x01020304.
REQ-037 Continuous 1 byte/cycle with out_ready=1 for 64 bytes -> in_ready stays 1 and 16 words are emitted back-to-back.

Source files
------------

// File: rtl/byte_packer_pkg.sv
// Shared definitions for the byte packer: output-register FSM states and
// the default word width in bytes.
package byte_packer_pkg;

    localparam int NBYTES_DEFAULT = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/out_reg_slice.sv
// One-entry output register with valid/ready handshake. FILL means empty,
// HOLD means a word is waiting for the consumer.
module out_reg_slice
    import byte_packer_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 3
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [DW-1:0] i_word,
    input  logic [CW-1:0] i_nbytes,
    input  logic          i_ready,
    output logic [DW-1:0] o_word,
    output logic [CW-1:0] o_nbytes,
    output logic          o_valid,
    output logic          o_free
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_word;
    logic [CW-1:0] r_nbytes;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (i_load) w_state_nxt = HOLD;
            HOLD:    if (i_ready && !i_load) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    // Data only changes on a load, so it stays put while the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_word   <= '0;
            r_nbytes <= '0;
        end else if (i_load) begin
            r_word   <= i_word;
            r_nbytes <= i_nbytes;
        end
    end

    assign o_word   = r_word;
    assign o_nbytes = r_nbytes;
    assign o_valid  = (r_state == HOLD);
    assign o_free   = !o_valid || i_ready;

endmodule

// File: rtl/byte_packer.sv
// Packs a serial byte stream into NBYTES-wide words with per-word endian
// selection and flush of partially assembled words.
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   in_byte,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         big_endian,
    input  logic                         flush,
    output logic [8*NBYTES-1:0]          out_word,
    output logic [$clog2(NBYTES+1)-1:0]  out_nbytes,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int              CW   = $clog2(NBYTES + 1);
    localparam logic [CW-1:0]   LAST = CW'(NBYTES - 1);

    logic [NBYTES-1:0][7:0] r_asm;
    logic [NBYTES-1:0][7:0] w_asm_nxt;
    logic [NBYTES-1:0]      w_hit;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_eff;
    logic [CW-1:0]          w_lane;
    logic                   r_be;
    logic                   r_flush_pend;
    logic                   w_mode;
    logic                   w_in_xfer;
    logic                   w_full;
    logic                   w_flush_req;
    logic                   w_flush_go;
    logic                   w_move;
    logic                   w_free;

    // A pending flush blocks input so the flushed word keeps its byte count.
    assign in_ready  = !reset && !r_flush_pend &&
                       !((r_cnt == LAST) && out_valid && !out_ready);
    assign w_in_xfer = in_valid && in_ready;

    assign w_mode    = (r_cnt == '0) ? big_endian : r_be;
    assign w_lane    = w_mode ? (LAST - r_cnt) : r_cnt;
    assign w_cnt_eff = r_cnt + {{(CW-1){1'b0}}, w_in_xfer};

    for (genvar g = 0; g < NBYTES; g++) begin : g_lane
        assign w_hit[g]     = (w_lane == CW'(g));
        assign w_asm_nxt[g] = (w_in_xfer && w_hit[g]) ? in_byte : r_asm[g];
    end

    // A full word absorbs a coincident flush; empty flushes never emit.
    assign w_full      = w_in_xfer && (r_cnt == LAST);
    assign w_flush_req = flush || r_flush_pend;
    assign w_flush_go  = w_flush_req && w_free && (w_cnt_eff != '0) && !w_full;
    assign w_move      = w_full || w_flush_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_asm        <= '0;
            r_be         <= 1'b1;
            r_flush_pend <= 1'b0;
        end else begin
            r_flush_pend <= w_flush_req && !w_move && (w_cnt_eff != '0);
            if (w_in_xfer && (r_cnt == '0)) begin
                r_be <= big_endian;
            end
            if (w_move) begin
                r_cnt <= '0;
                r_asm <= '0;
            end else begin
                r_cnt <= w_cnt_eff;
                r_asm <= w_asm_nxt;
            end
        end
    end

    out_reg_slice #(
        .DW (8*NBYTES),
        .CW (CW)
    ) u_out (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_load   (w_move),
        .i_word   (w_asm_nxt),
        .i_nbytes (w_cnt_eff),
        .i_ready  (out_ready),
        .o_word   (out_word),
        .o_nbytes (out_nbytes),
        .o_valid  (out_valid),
        .o_free   (w_free)
    );

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: vector table plus hand sequences,
// with a scoreboard queue compared against every output transfer.
module tb_byte_packer;

    localparam int NB = 4;
    localparam int CW = $clog2(NB + 1);

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      in_byte;
    logic            in_valid;
    logic            in_ready;
    logic            big_endian;
    logic            flush;
    logic [8*NB-1:0] out_word;
    logic [CW-1:0]   out_nbytes;
    logic            out_valid;
    logic            out_ready;

    always #5 clk = ~clk;

    byte_packer #(.NBYTES(NB)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .big_endian (big_endian),
        .flush      (flush),
        .out_word   (out_word),
        .out_nbytes (out_nbytes),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    typedef struct {
        logic [8*NB-1:0] w;
        logic [CW-1:0]   n;
    } exp_t;

    typedef struct {
        logic        be;
        int          n;
        logic [31:0] b;
        int          fm;   // 0 none, 1 flush cycle after, 2 flush with last byte
        logic [31:0] w;
        int          en;
    } vec_t;

    exp_t            q[$];
    int              tests = 0;
    int              fails = 0;
    int              n_out = 0;
    logic            hv = 1'b0;
    logic [8*NB-1:0] hw;
    logic [CW-1:0]   hn;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] w, input int n);
        exp_t e;
        e.w = w;
        e.n = n[CW-1:0];
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input logic be, input logic fl);
        int g = 0;
        in_byte = b; in_valid = 1'b1; big_endian = be; flush = fl;
        @(negedge clk);
        while (!in_ready && g < 100) begin
            g++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stuck 0 for byte %h", b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while (q.size() != 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d words still expected after %0d cycles", q.size(), g);
            q.delete();
        end
    endtask

    // Scoreboard and hold-stability monitor, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                hv = 1'b0;
            end else begin
                if (hv) begin
                    chk("hold_valid", out_valid, 1'b1);
                    chk("hold_word", out_word, hw);
                    chk("hold_nbytes", out_nbytes, hn);
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_word: got %h/%0d, none expected", out_word, out_nbytes);
                    end else begin
                        e = q.pop_front();
                        chk("out_word", out_word, e.w);
                        chk("out_nbytes", out_nbytes, e.n);
                    end
                end
                hv = out_valid && !out_ready;
                hw = out_word;
                hn = out_nbytes;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[9];
        logic [31:0] w;
        int          stalls;
        int          n0;

        vt[0] = '{1'b1, 4, 32'h11223344, 0, 32'h11223344, 4};
        vt[1] = '{1'b0, 4, 32'h11223344, 0, 32'h44332211, 4};
        vt[2] = '{1'b1, 2, 32'hAABB0000, 1, 32'hAABB0000, 2};
        vt[3] = '{1'b0, 2, 32'hAABB0000, 1, 32'h0000BBAA, 2};
        vt[4] = '{1'b1, 1, 32'h5A000000, 1, 32'h5A000000, 1};
        vt[5] = '{1'b0, 3, 32'h01020300, 1, 32'h00030201, 3};
        vt[6] = '{1'b1, 3, 32'h01020300, 1, 32'h01020300, 3};
        vt[7] = '{1'b1, 4, 32'hDEADBEEF, 2, 32'hDEADBEEF, 4};
        vt[8] = '{1'b0, 2, 32'h12340000, 2, 32'h00003412, 2};

        reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; big_endian = 1'b1;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_word", out_word, 0);
        chk("rst_out_nbytes", out_nbytes, 0);
        chk("rst_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1'b1);

        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < vt[i].n; j++)
                send(vt[i].b[31-8*j -: 8], vt[i].be, (vt[i].fm == 2) && (j == vt[i].n - 1));
            if (vt[i].fm == 1) pulse_flush();
            push_exp(vt[i].w, vt[i].en);
            chk($sformatf("vec%0d_latency", i), out_valid, 1'b1);
        end
        wait_drain();

        // flush with nothing assembled emits nothing
        pulse_flush();
        chk("flush_empty_now", out_valid, 1'b0);
        idle(3);
        chk("flush_empty_later", out_valid, 1'b0);

        // endian input changing mid-word is ignored
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        send(8'h44, 1'b1, 1'b0);
        push_exp(32'h44332211, 4);
        wait_drain();

        // backpressure: second word stalls on its last byte
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send(8'(k), 1'b1, 1'b0);
        push_exp(32'h01020304, 4);
        for (int k = 5; k <= 7; k++) send(8'(k), 1'b1, 1'b0);
        in_byte = 8'h08; in_valid = 1'b1; big_endian = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_word_held", out_word, 32'h01020304);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(8'h08, 1'b1, 1'b0);
        push_exp(32'h05060708, 4);
        wait_drain();

        // flush while the output register is occupied stays pending
        out_ready = 1'b0;
        send(8'hC1, 1'b0, 1'b0);
        send(8'hC2, 1'b0, 1'b0);
        send(8'hC3, 1'b0, 1'b0);
        send(8'hC4, 1'b0, 1'b0);
        push_exp(32'hC4C3C2C1, 4);
        send(8'h61, 1'b1, 1'b0);
        send(8'h62, 1'b1, 1'b0);
        pulse_flush();
        chk("pend_in_ready", in_ready, 1'b0);
        idle(2);
        chk("pend_in_ready_hold", in_ready, 1'b0);
        push_exp(32'h61620000, 2);
        out_ready = 1'b1;
        wait_drain();
        chk("pend_cleared", in_ready, 1'b1);

        // reset mid-word
        send(8'hE1, 1'b1, 1'b0);
        send(8'hE2, 1'b1, 1'b0);
        send(8'hE3, 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstw_in_ready", in_ready, 1'b0);
        chk("rstw_out_valid", out_valid, 1'b0);
        chk("rstw_out_word", out_word, 0);
        chk("rstw_out_nbytes", out_nbytes, 0);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) send(8'(k), 1'b1, 1'b0);
        push_exp(32'h01020304, 4);
        chk("rstw_latency", out_valid, 1'b1);
        wait_drain();

        // reset while a word is held and another is half built
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) send(8'(8'hA0 + k), 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rsth_out_valid", out_valid, 1'b0);
        chk("rsth_out_word", out_word, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        idle(3);
        chk("rsth_idle_valid", out_valid, 1'b0);
        for (int k = 5; k <= 8; k++) send(8'(k), 1'b0, 1'b0);
        push_exp(32'h08070605, 4);
        wait_drain();

        // 64-byte stream at one byte per cycle
        stalls = 0;
        n0 = n_out;
        for (int wd = 0; wd < 16; wd++) begin
            logic       bsel;
            logic [7:0] bv;
            bsel = 1'($urandom_range(0, 1));
            w = '0;
            for (int k = 0; k < 4; k++) begin
                bv = 8'($urandom_range(0, 255));
                in_byte = bv; in_valid = 1'b1;
                big_endian = (k == 0) ? bsel : ~bsel;
                if (bsel) w[(3-k)*8 +: 8] = bv;
                else      w[k*8 +: 8]     = bv;
                @(negedge clk);
                if (!in_ready) stalls++;
                @(posedge clk); #1;
            end
            push_exp(w, 4);
        end
        in_valid = 1'b0;
        idle(1);
        chk("stream_stalls", stalls, 0);
        chk("stream_words", n_out - n0, 16);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
